if_id_buffer: RTL

- Pipeline buffer between instruction_fetch and the decode stage.
- Captures fetched {pc, instruction} pairs through a valid/ready handshake in a 2-entry skid FIFO.
- Presents the head entry to decode, together with pre-split MIPS-style instruction fields.
- Supports branch/jump flush and decode backpressure without losing or duplicating instructions.

---
 rtl/if_id_buffer.sv | 110 +++++++++++
 1 files changed

// File: rtl/if_id_buffer.sv
// IF/ID pipeline buffer: a 2-entry skid FIFO of {pc, instruction} pairs between fetch and decode.
// The head entry is presented to decode with its MIPS-style fields already split out.
module if_id_buffer #(
   parameter int          PC_W      = 32,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            if_valid,
   output logic            if_ready,
   input  logic [PC_W-1:0] if_pc,
   input  logic [31:0]     if_instr,
   input  logic            flush,
   input  logic            id_ready,
   output logic            id_valid,
   output logic [PC_W-1:0] id_pc,
   output logic [31:0]     id_instr,
   output logic [5:0]      id_opcode,
   output logic [4:0]      id_rs,
   output logic [4:0]      id_rt,
   output logic [4:0]      id_rd,
   output logic [4:0]      id_shamt,
   output logic [5:0]      id_funct,
   output logic [31:0]     id_imm_sext,
   output logic [PC_W-1:0] id_jtarget,
   output logic            id_is_rtype,
   output logic [1:0]      count
);

   logic [1:0]      count_q, count_d;
   logic            wr_ptr_q, wr_ptr_d;
   logic            rd_ptr_q, rd_ptr_d;
   logic [PC_W-1:0] pc_mem_q    [2];
   logic [31:0]     instr_mem_q [2];

   logic push;
   logic pop;

   assign if_ready = (count_q < 2'd2);
   assign id_valid = (count_q != 2'd0);
   assign count    = count_q;

   assign push = if_valid & if_ready & ~flush;
   assign pop  = id_valid & id_ready & ~flush;

   always_comb begin
      count_d  = count_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush) begin
         count_d  = 2'd0;
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
      end else begin
         case ({push, pop})
            2'b11: begin
               wr_ptr_d = ~wr_ptr_q;
               rd_ptr_d = ~rd_ptr_q;
            end
            2'b10: begin
               wr_ptr_d = ~wr_ptr_q;
               count_d  = count_q + 2'd1;
            end
            2'b01: begin
               rd_ptr_d = ~rd_ptr_q;
               count_d  = count_q - 2'd1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count_q  <= 2'd0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
      end else begin
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: the head is masked whenever the buffer is empty.
   always_ff @(posedge clock) begin
      if (push) begin
         pc_mem_q[wr_ptr_q]    <= if_pc;
         instr_mem_q[wr_ptr_q] <= if_instr;
      end
   end

   assign id_pc    = id_valid ? pc_mem_q[rd_ptr_q]    : '0;
   assign id_instr = id_valid ? instr_mem_q[rd_ptr_q] : NOP_INSTR;

   assign id_opcode   = id_instr[31:26];
   assign id_rs       = id_instr[25:21];
   assign id_rt       = id_instr[20:16];
   assign id_rd       = id_instr[15:11];
   assign id_shamt    = id_instr[10:6];
   assign id_funct    = id_instr[5:0];
   assign id_imm_sext = {{16{id_instr[15]}}, id_instr[15:0]};
   assign id_is_rtype = id_valid & (id_opcode == 6'd0);

   // Upper bits of pc+4: a carry reaches bit 28 only when pc[27:2] is all ones.
   logic [PC_W-29:0] pc_hi;
   assign pc_hi      = id_pc[PC_W-1:28] + (PC_W-28)'(&id_pc[27:2]);
   assign id_jtarget = {pc_hi, id_instr[25:0], 2'b00};

endmodule
